// File: rtl/rsa_operand_sequencer_pkg.sv
// Shared types and codes for the RSA operand sequencer.
// Imported by the slot bank, the top and the bench.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_MOD  = 2'd1;
    localparam logic [1:0] ERR_TO   = 2'd2;
    localparam logic [1:0] ERR_BUSY = 2'd3;

    localparam logic [1:0] SEL_M = 2'd0;
    localparam logic [1:0] SEL_E = 2'd1;
    localparam logic [1:0] SEL_N = 2'd2;

    // Only odd moduli are usable; odd also implies nonzero.
    function automatic logic mod_ok(input logic n_lsb);
        return n_lsb;
    endfunction

endpackage

// File: rtl/rsa_operand_sequencer_if.sv
// Go/done handshake and operand bus between the sequencer
// and the Montgomery exponentiator.
interface rsa_operand_sequencer_if #(
    parameter int BITS = 128
);

    logic            exp_go;
    logic [BITS-1:0] exp_m;
    logic [BITS-1:0] exp_e;
    logic [BITS-1:0] exp_n;
    logic            exp_done;
    logic [BITS-1:0] exp_z;

    modport master (
        output exp_go,
        output exp_m,
        output exp_e,
        output exp_n,
        input  exp_done,
        input  exp_z
    );

    modport slave (
        input  exp_go,
        input  exp_m,
        input  exp_e,
        input  exp_n,
        output exp_done,
        output exp_z
    );

endinterface

// File: rtl/rsa_operand_sequencer_slot_bank.sv
// NSLOT x {M,E,N} serial shift-load registers with one
// combinational read port and a write lock for the active slot.
module rsa_slot_bank
    import rsa_pkg::*;
#(
    parameter int BITS  = 128,
    parameter int NSLOT = 4,
    parameter int DW    = 8,
    localparam int SW   = $clog2(NSLOT)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wr_en,
    input  logic [1:0]      i_wr_sel,
    input  logic [SW-1:0]   i_wr_slot,
    input  logic [DW-1:0]   i_wr_data,
    input  logic            i_lock_en,
    input  logic [SW-1:0]   i_lock_slot,
    input  logic [SW-1:0]   i_rd_slot,
    output logic [BITS-1:0] o_rd_m,
    output logic [BITS-1:0] o_rd_e,
    output logic [BITS-1:0] o_rd_n
);

    logic [BITS-1:0] r_m [NSLOT];
    logic [BITS-1:0] r_e [NSLOT];
    logic [BITS-1:0] r_n [NSLOT];

    logic w_locked;
    logic w_wr;

    assign w_locked = i_lock_en && (i_lock_slot == i_wr_slot);
    assign w_wr     = i_wr_en && (i_wr_sel != 2'd3) && !w_locked;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_m[i] <= '0;
                r_e[i] <= '0;
                r_n[i] <= '0;
            end
        end else if (w_wr) begin
            case (i_wr_sel)
                SEL_M: r_m[i_wr_slot] <=
                    {r_m[i_wr_slot][BITS-DW-1:0], i_wr_data};
                SEL_E: r_e[i_wr_slot] <=
                    {r_e[i_wr_slot][BITS-DW-1:0], i_wr_data};
                SEL_N: r_n[i_wr_slot] <=
                    {r_n[i_wr_slot][BITS-DW-1:0], i_wr_data};
                default: ;
            endcase
        end
    end

    assign o_rd_m = r_m[i_rd_slot];
    assign o_rd_e = r_e[i_rd_slot];
    assign o_rd_n = r_n[i_rd_slot];

endmodule

// File: rtl/rsa_operand_sequencer.sv
// Operand slot store and go/done sequencer for the RSA
// exponentiator, with watchdog, error status and result readout.
module rsa_operand_sequencer
    import rsa_pkg::*;
#(
    parameter int BITS    = 128,
    parameter int NSLOT   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1048575,
    localparam int SW     = $clog2(NSLOT),
    localparam int RW     = $clog2(BITS/16),
    localparam int CW     = $clog2(TIMEOUT+1)
) (
    input  logic            clock,
    input  logic            RESET,
    input  logic            wr_en,
    input  logic [1:0]      wr_sel,
    input  logic [SW-1:0]   wr_slot,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic [SW-1:0]   start_slot,
    output logic            busy,
    output logic            res_valid,
    output logic [1:0]      err,
    rsa_operand_sequencer_if.master exp,
    output logic [BITS-1:0] result,
    input  logic [RW-1:0]   rd_idx,
    output logic [15:0]     rd_word
);

    state_t r_state;
    state_t w_next;

    logic [SW-1:0]   r_slot;
    logic            r_busy;
    logic            r_valid;
    logic [1:0]      r_err;
    logic [BITS-1:0] r_m;
    logic [BITS-1:0] r_e;
    logic [BITS-1:0] r_n;
    logic [BITS-1:0] r_result;
    logic [CW-1:0]   r_wd;

    logic [BITS-1:0] w_m;
    logic [BITS-1:0] w_e;
    logic [BITS-1:0] w_n;
    logic            w_accept;
    logic            w_reject;
    logic            w_busy_start;
    logic            w_done;
    logic            w_timeout;

    rsa_slot_bank #(
        .BITS  (BITS),
        .NSLOT (NSLOT),
        .DW    (DW)
    ) u_bank (
        .i_clk       (clock),
        .i_reset     (RESET),
        .i_wr_en     (wr_en),
        .i_wr_sel    (wr_sel),
        .i_wr_slot   (wr_slot),
        .i_wr_data   (wr_data),
        .i_lock_en   (r_busy),
        .i_lock_slot (r_slot),
        .i_rd_slot   (start_slot),
        .o_rd_m      (w_m),
        .o_rd_e      (w_e),
        .o_rd_n      (w_n)
    );

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_busy_start = start && (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (!mod_ok(w_n[0])) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ISSUE;
                    end
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (exp.exp_done) begin
                    w_done = 1'b1;
                    w_next = DONE;
                end else if (r_wd == CW'(TIMEOUT-1)) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            r_wd <= '0;
        end else if (r_state == WAIT) begin
            r_wd <= r_wd + CW'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // Operands are snapshotted at acceptance so later slot
    // writes cannot disturb a run in flight.
    always_ff @(posedge clock) begin
        if (RESET) begin
            r_m    <= '0;
            r_e    <= '0;
            r_n    <= '0;
            r_slot <= '0;
        end else if (w_accept) begin
            r_m    <= w_m;
            r_e    <= w_e;
            r_n    <= w_n;
            r_slot <= start_slot;
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= ERR_NONE;
        end else begin
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
                r_err   <= ERR_NONE;
            end
            if (w_reject) begin
                r_err <= ERR_MOD;
            end
            if (w_busy_start) begin
                r_err <= ERR_BUSY;
            end
            if (w_timeout) begin
                r_busy <= 1'b0;
                r_err  <= ERR_TO;
            end
            if (r_state == DONE) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            r_result <= '0;
        end else if (w_done) begin
            r_result <= exp.exp_z;
        end
    end

    assign exp.exp_go = (r_state == ISSUE);
    assign exp.exp_m  = r_m;
    assign exp.exp_e  = r_e;
    assign exp.exp_n  = r_n;

    assign busy      = r_busy;
    assign res_valid = r_valid;
    assign err       = r_err;
    assign result    = r_result;
    assign rd_word   = r_result[16*rd_idx +: 16];

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Scoreboard bench for rsa_operand_sequencer: a behavioural
// exponentiator answers go pulses; a second instance exercises the watchdog.
module tb_rsa_operand_sequencer;
    import rsa_pkg::*;

    localparam int BITS  = 128;
    localparam int NSLOT = 4;
    localparam int DW    = 8;
    localparam int LAT   = 100;
    localparam int TO2   = 50;

    logic            clock = 1'b0;
    logic            RESET;
    logic            wr_en;
    logic [1:0]      wr_sel;
    logic [1:0]      wr_slot;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic [1:0]      start_slot;
    logic [2:0]      rd_idx;

    logic            busy, res_valid;
    logic [1:0]      err;
    logic [BITS-1:0] result;
    logic [15:0]     rd_word;

    logic            busy2, res_valid2;
    logic [1:0]      err2;
    logic [BITS-1:0] result2;
    logic [15:0]     rd_word2;

    rsa_operand_sequencer_if #(.BITS(BITS)) ex ();
    rsa_operand_sequencer_if #(.BITS(BITS)) ex2 ();

    rsa_operand_sequencer #(
        .BITS(BITS), .NSLOT(NSLOT), .DW(DW)
    ) dut (
        .clock(clock), .RESET(RESET),
        .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_slot(wr_slot), .wr_data(wr_data),
        .start(start), .start_slot(start_slot),
        .busy(busy), .res_valid(res_valid), .err(err),
        .exp(ex.master),
        .result(result), .rd_idx(rd_idx), .rd_word(rd_word)
    );

    rsa_operand_sequencer #(
        .BITS(BITS), .NSLOT(NSLOT), .DW(DW), .TIMEOUT(TO2)
    ) dut_to (
        .clock(clock), .RESET(RESET),
        .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_slot(wr_slot), .wr_data(wr_data),
        .start(start), .start_slot(start_slot),
        .busy(busy2), .res_valid(res_valid2), .err(err2),
        .exp(ex2.master),
        .result(result2), .rd_idx(rd_idx), .rd_word(rd_word2)
    );

    assign ex2.exp_done = 1'b0;
    assign ex2.exp_z    = '0;

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BITS-1:0] sb_q [$];
    logic [BITS-1:0] sh_m [NSLOT];
    logic [BITS-1:0] sh_e [NSLOT];
    logic [BITS-1:0] sh_n [NSLOT];

    bit              model_en   = 1'b1;
    bit              pulse_done = 1'b0;
    bit              m_busy;
    int              m_cnt;
    logic [BITS-1:0] m_z;

    function automatic logic [BITS-1:0] modexp(
        input logic [BITS-1:0] b,
        input logic [BITS-1:0] e,
        input logic [BITS-1:0] n
    );
        logic [2*BITS-1:0] r;
        logic [2*BITS-1:0] x;
        logic [2*BITS-1:0] nn;
        nn = {{BITS{1'b0}}, n};
        r  = 1;
        x  = {{BITS{1'b0}}, b} % nn;
        for (int i = 0; i < BITS; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[BITS-1:0];
    endfunction

    // Behavioural exponentiator: answers LAT cycles after go.
    always @(posedge clock) begin
        ex.exp_done <= 1'b0;
        if (RESET) begin
            m_busy   <= 1'b0;
            ex.exp_z <= '0;
        end else if (pulse_done) begin
            ex.exp_done <= 1'b1;
            ex.exp_z    <= 128'h1234;
        end else if (ex.exp_go && model_en) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT - 1;
            m_z    <= modexp(ex.exp_m, ex.exp_e, ex.exp_n);
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                ex.exp_done <= 1'b1;
                ex.exp_z    <= m_z;
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic load(
        input int              slot,
        input logic [1:0]      sel,
        input logic [BITS-1:0] v,
        input bit              track
    );
        for (int i = 0; i < BITS/DW; i++) begin
            @(negedge clock);
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_slot = 2'(slot);
            wr_data = v[BITS-1-i*DW -: DW];
        end
        @(negedge clock);
        wr_en = 1'b0;
        if (track) begin
            case (sel)
                SEL_M: sh_m[slot] = v;
                SEL_E: sh_e[slot] = v;
                default: sh_n[slot] = v;
            endcase
        end
    endtask

    // Returns at the negedge after the accepting edge (ISSUE).
    task automatic do_start(input int slot);
        @(negedge clock);
        start      = 1'b1;
        start_slot = 2'(slot);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!busy && !busy2) break;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge clock);
        RESET = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({busy, res_valid, err, ex.exp_go} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {busy, res_valid, err, ex.exp_go});
        end
        n_tests++;
        if ((result | ex.exp_m | ex.exp_n) !== '0) begin
            n_fail++;
            $display("FAIL reset_data got r=%0h m=%0h n=%0h want 0",
                     result, ex.exp_m, ex.exp_n);
        end
    endtask

    task automatic test_basic();
        bit got;
        logic [BITS-1:0] want;
        load(0, SEL_M, 128'd65, 1'b1);
        load(0, SEL_E, 128'd17, 1'b1);
        load(0, SEL_N, 128'd3233, 1'b1);
        sb_q.push_back(modexp(sh_m[0], sh_e[0], sh_n[0]));
        do_start(0);
        n_tests++;
        if (ex.exp_go !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_go got go=%b busy=%b want 1 1",
                     ex.exp_go, busy);
        end
        n_tests++;
        if (ex.exp_n !== 128'd3233) begin
            n_fail++;
            $display("FAIL basic_exp_n got %0d want 3233", ex.exp_n);
        end
        wait_valid(got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL basic_done got no res_valid want 1");
        end
        want = sb_q.pop_front();
        n_tests++;
        if (result !== want) begin
            n_fail++;
            $display("FAIL basic_result got %0d want %0d", result, want);
        end
        rd_idx = 3'd0;
        #1;
        n_tests++;
        if (rd_word !== 16'h0AE6) begin
            n_fail++;
            $display("FAIL basic_rd0 got %h want 0ae6", rd_word);
        end
        rd_idx = 3'd1;
        #1;
        n_tests++;
        if (rd_word !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_rd1 got %h want 0000", rd_word);
        end
        rd_idx = 3'd0;
        n_tests++;
        if (res_valid !== 1'b1 || err !== ERR_NONE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status got v=%b e=%0d b=%b want 1 0 0",
                     res_valid, err, busy);
        end
    endtask

    task automatic test_bad_mod();
        bit seen_go;
        load(1, SEL_M, 128'd5, 1'b1);
        load(1, SEL_E, 128'd3, 1'b1);
        load(1, SEL_N, 128'd3232, 1'b1);
        wait_idle();
        do_start(1);
        seen_go = ex.exp_go;
        repeat (4) begin
            @(negedge clock);
            seen_go |= ex.exp_go;
        end
        n_tests++;
        if (seen_go !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL badmod_go got go=%b busy=%b want 0 0",
                     seen_go, busy);
        end
        n_tests++;
        if (err !== ERR_MOD) begin
            n_fail++;
            $display("FAIL badmod_err got %0d want 1", err);
        end
    endtask

    task automatic test_busy_start();
        bit got;
        logic [BITS-1:0] want;
        wait_idle();
        sb_q.push_back(modexp(sh_m[0], sh_e[0], sh_n[0]));
        do_start(0);
        repeat (10) @(negedge clock);
        do_start(0);
        n_tests++;
        if (err !== ERR_BUSY || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_err got e=%0d b=%b want 3 1", err, busy);
        end
        wait_valid(got);
        want = sb_q.pop_front();
        n_tests++;
        if (!got || result !== want) begin
            n_fail++;
            $display("FAIL busy_result got %0d (v=%b) want %0d",
                     result, got, want);
        end
        n_tests++;
        if (err !== ERR_BUSY) begin
            n_fail++;
            $display("FAIL busy_err_sticky got %0d want 3", err);
        end
    endtask

    task automatic test_load_during_wait();
        bit got;
        logic [BITS-1:0] want;
        load(2, SEL_M, 128'd1, 1'b1);
        load(2, SEL_E, 128'd3, 1'b1);
        load(2, SEL_N, 128'd33, 1'b1);
        wait_idle();
        sb_q.push_back(modexp(sh_m[0], sh_e[0], sh_n[0]));
        do_start(0);
        load(0, SEL_N, {BITS{1'b1}}, 1'b0);
        load(2, SEL_M, 128'd7, 1'b1);
        n_tests++;
        if (busy !== 1'b1 || ex.exp_n !== sh_n[0]) begin
            n_fail++;
            $display("FAIL lock_exp_n got %0h (b=%b) want %0h",
                     ex.exp_n, busy, sh_n[0]);
        end
        wait_valid(got);
        want = sb_q.pop_front();
        n_tests++;
        if (!got || result !== want) begin
            n_fail++;
            $display("FAIL lock_result got %0d want %0d", result, want);
        end
        wait_idle();
        sb_q.push_back(modexp(sh_m[2], sh_e[2], sh_n[2]));
        do_start(2);
        n_tests++;
        if (ex.exp_m !== 128'd7) begin
            n_fail++;
            $display("FAIL slot2_m got %0d want 7", ex.exp_m);
        end
        wait_valid(got);
        want = sb_q.pop_front();
        n_tests++;
        if (!got || result !== want) begin
            n_fail++;
            $display("FAIL slot2_result got %0d want %0d", result, want);
        end
        wait_idle();
        do_start(0);
        n_tests++;
        if (ex.exp_n !== 128'd3233 || ex.exp_go !== 1'b1) begin
            n_fail++;
            $display("FAIL slot0_kept got n=%0d go=%b want 3233 1",
                     ex.exp_n, ex.exp_go);
        end
        sb_q.push_back(modexp(sh_m[0], sh_e[0], sh_n[0]));
        wait_valid(got);
        want = sb_q.pop_front();
        n_tests++;
        if (!got || result !== want) begin
            n_fail++;
            $display("FAIL slot0_result got %0d want %0d", result, want);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit ended;
        wait_idle();
        model_en = 1'b0;
        do_start(0);
        cnt   = 0;
        ended = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy2) begin
                ended = 1'b1;
                break;
            end
            if (!ex2.exp_go) cnt++;
        end
        n_tests++;
        if (!ended || cnt != TO2) begin
            n_fail++;
            $display("FAIL timeout_cycles got %0d (ended=%b) want %0d",
                     cnt, ended, TO2);
        end
        n_tests++;
        if (err2 !== ERR_TO || busy2 !== 1'b0 || res_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_status got e=%0d b=%b v=%b want 2 0 0",
                     err2, busy2, res_valid2);
        end
        n_tests++;
        if (result2 !== '0) begin
            n_fail++;
            $display("FAIL timeout_result got %0h want 0", result2);
        end
    endtask

    task automatic test_reset_mid_wait();
        n_tests++;
        if (busy !== 1'b1 || dut.r_state !== WAIT) begin
            n_fail++;
            $display("FAIL rst_pre got busy=%b st=%0d want 1 %0d",
                     busy, dut.r_state, WAIT);
        end
        @(negedge clock);
        RESET = 1'b1;
        @(negedge clock);
        RESET = 1'b0;
        pulse_done = 1'b1;
        @(negedge clock);
        pulse_done = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({busy, res_valid, err, ex.exp_go} !== 5'b0 ||
            dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_flags got %b st=%0d want 00000 %0d",
                     {busy, res_valid, err, ex.exp_go}, dut.r_state, IDLE);
        end
        n_tests++;
        if ((result | ex.exp_m | ex.exp_e | ex.exp_n) !== '0 ||
            rd_word !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_data got r=%0h m=%0h n=%0h w=%h want 0",
                     result, ex.exp_m, ex.exp_n, rd_word);
        end
    endtask

    initial begin
        RESET      = 1'b1;
        wr_en      = 1'b0;
        wr_sel     = 2'd0;
        wr_slot    = 2'd0;
        wr_data    = '0;
        start      = 1'b0;
        start_slot = 2'd0;
        rd_idx     = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            sh_m[i] = '0;
            sh_e[i] = '0;
            sh_n[i] = '0;
        end
        test_reset();
        test_basic();
        test_bad_mod();
        test_busy_start();
        test_load_during_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
